// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Brief    : N-port arbiter onto one SDRAM controller interface; round-robin
//            or fixed priority, owner switch only when controller is idle.
// Revision : 1.0
// ============================================================================
module sdram_port_arbiter #(
  parameter int PORTS     = 3,
  parameter int AW        = 32,
  parameter int DW        = 16,
  parameter int PRIO_MODE = 0,
  parameter int MAX_HOLD  = 8
) (
  input  logic                     sdram_clk,
  input  logic                     sdram_rst,
  input  logic                     sdram_idle_i,
  input  logic [PORTS*AW-1:0]      p_adr_i,
  input  logic [PORTS*DW-1:0]      p_dat_i,
  input  logic [PORTS*DW/8-1:0]    p_sel_i,
  input  logic [PORTS-1:0]         p_we_i,
  input  logic [PORTS-1:0]         p_acc_i,
  output logic [PORTS-1:0]         p_ack_o,
  output logic [AW-1:0]            adr_o,
  output logic [DW-1:0]            dat_o,
  output logic [DW/8-1:0]          sel_o,
  output logic                     we_o,
  output logic                     acc_o,
  input  logic                     ack_i,
  output logic [PORTS-1:0]         grant_o,
  output logic [$clog2(PORTS)-1:0] grant_enc_o
);

  localparam int EW = $clog2(PORTS);
  localparam int SW = DW / 8;
  localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] c_hold_max  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] c_hold_last = (MAX_HOLD > 0) ? HW'(MAX_HOLD - 1) : '0;

  typedef enum logic [0:0] {
    ST_OWN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          r_state;
  logic [EW-1:0]   r_owner;
  logic [HW-1:0]   r_hold;

  logic [PORTS-1:0] w_grant;
  logic [PORTS-1:0] w_others;
  logic [PORTS-1:0] w_cand;
  logic             w_any_other;
  logic             w_acc;
  logic             w_safe;
  logic [EW-1:0]    w_next;

  always_comb begin
    w_grant = '0;
    for (int i = 0; i < PORTS; i++) begin
      w_grant[i] = (r_owner == EW'(i));
    end
  end

  always_comb begin
    adr_o = '0;
    dat_o = '0;
    sel_o = '0;
    we_o  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (w_grant[i]) begin
        adr_o = p_adr_i[i*AW +: AW];
        dat_o = p_dat_i[i*DW +: DW];
        sel_o = p_sel_i[i*SW +: SW];
        we_o  = p_we_i[i];
      end
    end
  end

  assign w_acc       = (r_state == ST_OWN) & (|(p_acc_i & w_grant));
  assign w_safe      = sdram_idle_i & ~w_acc;
  assign w_others    = p_acc_i & ~w_grant;
  assign w_any_other = |w_others;
  // While draining, the preempted owner only wins if nobody else is asking.
  assign w_cand      = ((r_state == ST_DRAIN) && w_any_other) ? w_others : p_acc_i;

  generate
    if (PRIO_MODE == 0) begin : g_rr
      always_comb begin
        w_next = r_owner;
        // Descending distance so the nearest requester after the owner wins.
        for (int k = PORTS; k >= 1; k--) begin
          for (int j = 0; j < PORTS; j++) begin
            if (w_cand[j] &&
                (j == ((int'(r_owner) + k >= PORTS) ? int'(r_owner) + k - PORTS
                                                     : int'(r_owner) + k))) begin
              w_next = EW'(j);
            end
          end
        end
      end
    end else begin : g_prio
      always_comb begin
        w_next = r_owner;
        for (int j = PORTS - 1; j >= 0; j--) begin
          if (w_cand[j]) begin
            w_next = EW'(j);
          end
        end
      end
    end
  endgenerate

  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      r_owner <= '0;
      r_state <= ST_OWN;
      r_hold  <= '0;
    end else if (w_safe) begin
      r_owner <= w_next;
      r_state <= ST_OWN;
      r_hold  <= '0;
    end else if ((r_state == ST_OWN) && ack_i) begin
      if (r_hold != c_hold_max) begin
        r_hold <= r_hold + HW'(1);
      end
      if ((MAX_HOLD != 0) && (r_hold == c_hold_last) && w_any_other) begin
        r_state <= ST_DRAIN;
      end
    end
  end

  assign acc_o       = w_acc;
  assign p_ack_o     = {PORTS{ack_i}} & w_grant;
  assign grant_o     = w_grant;
  assign grant_enc_o = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_port_arbiter
// Brief    : Scoreboard bench for sdram_port_arbiter, round-robin and
//            fixed-priority instances driven by the same stimulus.
// Revision : 1.0
// ============================================================================
module tb_sdram_port_arbiter;

  localparam int P = 3;

  typedef struct packed {
    logic [2:0]  grant;
    logic [1:0]  enc;
    logic        acc;
    logic [2:0]  ack;
    logic [31:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        tb_rst = 1'b1;
  logic        tb_idle = 1'b0;
  logic        tb_ack = 1'b0;
  logic [2:0]  tb_acc = 3'b000;
  logic [31:0] tb_adr [P];
  logic [15:0] tb_dat [P];
  logic [1:0]  tb_sel [P];
  logic [2:0]  tb_we = 3'b000;

  logic [95:0] w_adr;
  logic [47:0] w_dat;
  logic [5:0]  w_sel;
  assign w_adr = {tb_adr[2], tb_adr[1], tb_adr[0]};
  assign w_dat = {tb_dat[2], tb_dat[1], tb_dat[0]};
  assign w_sel = {tb_sel[2], tb_sel[1], tb_sel[0]};

  logic [2:0]  rr_ack, rr_grant, fp_ack, fp_grant;
  logic [31:0] rr_adr, fp_adr;
  logic [15:0] rr_dat, fp_dat;
  logic [1:0]  rr_sel, fp_sel, rr_enc, fp_enc;
  logic        rr_we, fp_we, rr_acc, fp_acc;

  sdram_port_arbiter #(.PORTS(3), .AW(32), .DW(16), .PRIO_MODE(0), .MAX_HOLD(4)) u_rr (
    .sdram_clk(clk), .sdram_rst(tb_rst), .sdram_idle_i(tb_idle),
    .p_adr_i(w_adr), .p_dat_i(w_dat), .p_sel_i(w_sel), .p_we_i(tb_we),
    .p_acc_i(tb_acc), .p_ack_o(rr_ack), .adr_o(rr_adr), .dat_o(rr_dat),
    .sel_o(rr_sel), .we_o(rr_we), .acc_o(rr_acc), .ack_i(tb_ack),
    .grant_o(rr_grant), .grant_enc_o(rr_enc)
  );

  sdram_port_arbiter #(.PORTS(3), .AW(32), .DW(16), .PRIO_MODE(1), .MAX_HOLD(0)) u_fp (
    .sdram_clk(clk), .sdram_rst(tb_rst), .sdram_idle_i(tb_idle),
    .p_adr_i(w_adr), .p_dat_i(w_dat), .p_sel_i(w_sel), .p_we_i(tb_we),
    .p_acc_i(tb_acc), .p_ack_o(fp_ack), .adr_o(fp_adr), .dat_o(fp_dat),
    .sel_o(fp_sel), .we_o(fp_we), .acc_o(fp_acc), .ack_i(tb_ack),
    .grant_o(fp_grant), .grant_enc_o(fp_enc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: index 0 = round-robin/hold 4, index 1 = fixed/hold never
  int m_owner [2] = '{0, 0};
  bit m_drain [2] = '{0, 0};
  int m_hold  [2] = '{0, 0};
  int m_mode  [2] = '{0, 1};
  int m_max   [2] = '{4, 0};

  exp_t q_rr [$];
  exp_t q_fp [$];

  function automatic exp_t model_out(int d);
    exp_t e;
    int o;
    o = m_owner[d];
    e.grant = 3'(1 << o);
    e.enc   = 2'(o);
    e.acc   = !m_drain[d] && tb_acc[o];
    e.ack   = tb_ack ? e.grant : 3'b000;
    e.adr   = tb_adr[o];
    e.dat   = tb_dat[o];
    e.sel   = tb_sel[o];
    e.we    = tb_we[o];
    return e;
  endfunction

  function automatic bit eligible(int d, int j, bit others);
    return tb_acc[j] && !(m_drain[d] && others && (j == m_owner[d]));
  endfunction

  task automatic model_next(int d, bit acc_o);
    int  o;
    int  pick;
    bit  others;
    o = m_owner[d];
    pick = -1;
    others = 1'b0;
    for (int j = 0; j < P; j++) if (j != o && tb_acc[j]) others = 1'b1;
    if (tb_rst) begin
      m_owner[d] = 0;
      m_drain[d] = 1'b0;
      m_hold[d]  = 0;
    end else if (tb_idle && !acc_o) begin
      if (m_mode[d] == 0) begin
        for (int k = 1; k <= P && pick < 0; k++)
          if (eligible(d, (o + k) % P, others)) pick = (o + k) % P;
      end else begin
        for (int j = 0; j < P && pick < 0; j++)
          if (eligible(d, j, others)) pick = j;
      end
      if (pick >= 0) m_owner[d] = pick;
      m_drain[d] = 1'b0;
      m_hold[d]  = 0;
    end else if (!m_drain[d] && tb_ack) begin
      if (m_max[d] != 0 && m_hold[d] == m_max[d] - 1 && others) m_drain[d] = 1'b1;
      if (m_hold[d] < m_max[d]) m_hold[d]++;
    end
  endtask

  // One clock of stimulus: drive at negedge, queue expectations, settle.
  task automatic cyc(input bit rst, input bit [2:0] acc, input bit idle, input bit ack);
    exp_t e0, e1;
    @(negedge clk);
    tb_rst  = rst;
    tb_acc  = acc;
    tb_idle = idle;
    tb_ack  = ack;
    for (int j = 0; j < P; j++) begin
      tb_adr[j] = $urandom;
      tb_dat[j] = 16'($urandom);
      tb_sel[j] = 2'($urandom);
    end
    tb_we = 3'($urandom);
    e0 = model_out(0);
    e1 = model_out(1);
    q_rr.push_back(e0);
    q_fp.push_back(e1);
    model_next(0, e0.acc);
    model_next(1, e1.acc);
    #2;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e, a;
    forever begin
      @(negedge clk);
      #2;
      if (q_rr.size() > 0) begin
        e = q_rr.pop_front();
        a = {rr_grant, rr_enc, rr_acc, rr_ack, rr_adr, rr_dat, rr_sel, rr_we};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL sb_rr t=%0t got %h expected %h", $time, a, e);
        end
      end
      if (q_fp.size() > 0) begin
        e = q_fp.pop_front();
        a = {fp_grant, fp_enc, fp_acc, fp_ack, fp_adr, fp_dat, fp_sel, fp_we};
        n_tests++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL sb_fp t=%0t got %h expected %h", $time, a, e);
        end
      end
    end
  end

  initial begin : stim
    bit [2:0] acc;
    for (int j = 0; j < P; j++) begin
      tb_adr[j] = '0;
      tb_dat[j] = '0;
      tb_sel[j] = '0;
    end
    repeat (2) @(posedge clk);

    // Reset state held with no requests
    cyc(1, 3'b000, 1, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 3'b000, 1, 0);
      chk("rst_grant", 32'(rr_grant), 32'h1);
      chk("rst_acc", 32'(rr_acc), 32'h0);
      chk("rst_ack", 32'(rr_ack), 32'h0);
    end

    // Round-robin rotation, one beat per port
    cyc(1, 3'b000, 1, 0);
    cyc(0, 3'b111, 1, 1); chk("rr_g0", 32'(rr_grant), 32'h1);
    cyc(0, 3'b110, 1, 0); chk("rr_hold_g0", 32'(rr_grant), 32'h1);
    cyc(0, 3'b111, 1, 1); chk("rr_g1", 32'(rr_grant), 32'h2);
    cyc(0, 3'b101, 1, 0);
    cyc(0, 3'b111, 1, 1); chk("rr_g2", 32'(rr_grant), 32'h4);
    cyc(0, 3'b011, 1, 0);
    cyc(0, 3'b011, 1, 0); chk("rr_wrap", 32'(rr_grant), 32'h1);

    // Fixed priority: port0 overtakes, port2 starved
    cyc(1, 3'b000, 1, 0);
    cyc(0, 3'b110, 1, 0);
    cyc(0, 3'b110, 1, 1); chk("fp_g1", 32'(fp_grant), 32'h2);
    cyc(0, 3'b111, 1, 0); chk("fp_busy", 32'(fp_grant), 32'h2);
    cyc(0, 3'b101, 1, 0);
    cyc(0, 3'b111, 1, 0); chk("fp_g0", 32'(fp_grant), 32'h1);
    cyc(0, 3'b110, 1, 0);
    cyc(0, 3'b111, 1, 0); chk("fp_starve2", 32'(fp_grant), 32'h2);

    // Hold limit preemption after the fourth ack
    cyc(1, 3'b000, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 3'b011, 0, 1);
      chk("mh_acc_stream", 32'(rr_acc), 32'h1);
    end
    cyc(0, 3'b011, 0, 0); chk("mh_drain_acc", 32'(rr_acc), 32'h0);
    cyc(0, 3'b011, 1, 0); chk("mh_drain_g", 32'(rr_grant), 32'h1);
    cyc(0, 3'b011, 1, 0); chk("mh_g1", 32'(rr_grant), 32'h2);
    cyc(0, 3'b011, 1, 1); chk("mh_ack1", 32'(rr_ack), 32'h2);
    cyc(0, 3'b001, 1, 0);
    cyc(0, 3'b001, 1, 0); chk("mh_resume", 32'(rr_grant), 32'h1);
    chk("mh_resume_acc", 32'(rr_acc), 32'h1);

    // Sole requester is never preempted
    cyc(1, 3'b000, 1, 0);
    for (int i = 0; i < 20; i++) cyc(0, 3'b001, 0, 1);
    chk("solo_grant", 32'(rr_grant), 32'h1);
    chk("solo_acc", 32'(rr_acc), 32'h1);

    // Reset in the middle of a port2 burst clears owner and hold count
    cyc(1, 3'b000, 1, 0);
    cyc(0, 3'b100, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 3'b100, 0, 1);
    chk("mid_g2", 32'(rr_grant), 32'h4);
    cyc(1, 3'b100, 0, 1);
    cyc(0, 3'b100, 0, 0);
    chk("mid_rst_g", 32'(rr_grant), 32'h1);
    chk("mid_rst_enc", 32'(rr_enc), 32'h0);
    chk("mid_rst_acc", 32'(rr_acc), 32'h0);
    for (int i = 0; i < 4; i++) cyc(0, 3'b011, 0, 1);
    chk("mid_cnt_acc", 32'(rr_acc), 32'h1);
    cyc(0, 3'b011, 0, 0);
    chk("mid_cnt_drain", 32'(rr_acc), 32'h0);

    // Randomised traffic with persistent request levels
    acc = 3'b000;
    for (int i = 0; i < 3000; i++) begin
      for (int j = 0; j < P; j++)
        if ($urandom_range(5) == 0) acc[j] = ~acc[j];
      cyc(($urandom_range(299) == 0), acc, 1'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    #4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
